mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO registers. It is the sequential companion to the single-cycle ALU in the execute stage. It accepts one MULT/MULTU/DIV/DIVU (or MTHI/MTLO) request at a time. Results are computed one bit per cycle and written to architectural HI/LO registers. It raises `busy` so the pipeline can stall later HI/LO readers or new MDU instructions.

## Interface
- `WIDTH`, default 32: operand, HI and LO width (≥4, even).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe; sampled only while idle.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB (6/7 only with `MDU_MADD_EN`).
- `src_a` in WIDTH: multiplicand / dividend / MTHI-MTLO data.
- `src_b` in WIDTH: multiplier / divisor.
- `flush` in 1: cancel in-flight operation (exception/branch kill).
- `busy` out 1: operation in flight; high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when HI/LO have just been written by a computed op.
- `div_zero` out 1: pulses with `done` when a DIV/DIVU had divisor 0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- FSM states:
  - IDLE → CALC on an accepted `start` with op 0–3 (or 6–7 when enabled).
  - CALC → FIX after WIDTH iterations.
  - FIX → IDLE unconditionally.
- IDLE, `start`, op 4/5: `hi`/`lo` load `src_a` on that edge. No busy, no done.
- Any unsupported op is ignored: no state change, no register write.
- `start` while not IDLE is ignored; the issuing stage must hold its instruction while `busy`.
- On accept, operands are latched. Signed ops (0, 2, 6, 7) latch magnitudes plus result sign flags. An iteration counter is cleared.
- Multiply, CALC: radix-2 shift-add into a 2·WIDTH product register, one multiplier bit per cycle.
- Divide, CALC: restoring divide, one quotient bit per cycle. Remainder and quotient are unsigned magnitudes.
- FIX:
  - Apply sign correction:
    - product negated if operand signs differ;
    - quotient negated if signs differ;
    - remainder takes the dividend's sign.
  - Write HI = upper/remainder, LO = lower/quotient.
  - Pulse `done`.
- Arithmetic rules:
  - Truncating division toward zero.
  - All negation modulo 2^WIDTH, so MIN/−1 gives LO = MIN, HI = 0.
- Divide by zero, at FIX:
  - LO = all ones, HI = dividend unchanged (raw `src_a`).
  - `div_zero` = 1 with `done`.
- `flush`, while CALC or FIX: return to IDLE next edge. HI/LO unchanged, no `done`. `flush` has priority over the FIX write.
- `flush` and `start` in the same IDLE cycle: `start` ignored.

## Timing
- Reset (async, `rst_n` = 0): state IDLE, `busy` 0, `done` 0, `div_zero` 0, `hi` 0, `lo` 0, counter and internal registers 0.
- Reset mid-operation: aborts immediately to the values above.
- Request accepted at edge k:
  - `busy` high after edges k … k+WIDTH (WIDTH+1 cycles).
  - HI/LO written and `done` high after edge k+WIDTH+1; `busy` low in that same cycle.
- Back-to-back: a new `start` is accepted in the cycle `done` is high.
- MTHI/MTLO latency: one edge.
- `hi`/`lo` are registered outputs, stable between writes.

## Configuration
- `MDU_MADD_EN` defined:
  - op 6 MADD: {HI,LO} += signed product.
  - op 7 MSUB: {HI,LO} −= signed product.
  - Both use the same CALC latency. The accumulate is performed in FIX, modulo 2^(2·WIDTH), using the HI/LO values at FIX time.
- `MDU_MADD_EN` undefined: ops 6/7 are unsupported (ignored, as above). No accumulate adder is built.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → after 33 busy cycles: `hi` 0xFFFFFFFF, `lo` 0xFFFFFFFE, `done` pulse. MULTU with the same operands → `hi` 0x00000001, `lo` 0xFFFFFFFE.
- DIV −7 (0xFFFFFFF9) / 2 → `lo` 0xFFFFFFFD, `hi` 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo` 0x80000000, `hi` 0.
- DIVU 5 / 0 → `lo` 0xFFFFFFFF, `hi` 5, `div_zero` and `done` high for one cycle.
- MULT 3×4 started, `flush` at busy cycle 10 → IDLE next cycle, `hi`/`lo` keep prior values, no `done`. Then `start` while busy → ignored. Then MTLO 0x1234 while idle → `lo` 0x1234 after one edge, `busy` stays 0.
- `rst_n` low mid-DIVU → `busy` 0 and `hi`/`lo` 0 immediately, without waiting for a clock edge.
- With `MDU_MADD_EN`: MTHI 0, MTLO 0xFFFFFFFF, then MADD 1×1 → `hi` 1, `lo` 0. MSUB 1×1 → `hi` 0, `lo` 0xFFFFFFFF. Without the macro: op 6 → no busy, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers; one result bit per cycle.
// Define MDU_MADD_EN to add MADD/MSUB (ops 6/7) accumulating into {HI,LO}.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  // Multiply: {partial high, remaining multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb, a_raw;
  logic               is_div, neg_res, neg_rem, dz_q;
`ifdef MDU_MADD_EN
  logic               macc, msub;
`endif

  logic               calc_op, sgn_op, op_div, idle_go, accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  always_comb begin
    calc_op = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: calc_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:                   calc_op = 1'b1;
`endif
      default:                            calc_op = 1'b0;
    endcase
  end

  assign sgn_op  = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign op_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign idle_go = (state == IDLE) && start && !flush;
  assign accept  = idle_go && calc_op;
  assign a_neg   = sgn_op & src_a[WIDTH-1];
  assign b_neg   = sgn_op & src_b[WIDTH-1];
  assign a_mag   = a_neg ? -src_a : src_a;
  assign b_mag   = b_neg ? -src_b : src_b;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: shift-add multiply step or restoring divide step.
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, opb};
    // The true difference is below opb, so the low WIDTH bits are exact.
    div_rem = div_sh[WIDTH-1:0] - opb;
    if (is_div)
      step = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    else
      step = {mul_sum, acc[WIDTH-1:1]};
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    prod_s = neg_res ? -acc : acc;
    quo    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      if (dz_q) begin
        fix_hi = a_raw;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end else begin
      {fix_hi, fix_lo} = prod_s;
`ifdef MDU_MADD_EN
      if (macc)
        {fix_hi, fix_lo} = msub ? ({hi, lo} - prod_s) : ({hi, lo} + prod_s);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_q     <= 1'b0;
`ifdef MDU_MADD_EN
      macc     <= 1'b0;
      msub     <= 1'b0;
`endif
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_go && op == OP_MTHI) hi <= src_a;
          if (idle_go && op == OP_MTLO) lo <= src_a;
          if (accept) begin
            acc     <= op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opb     <= op_div ? b_mag : a_mag;
            a_raw   <= src_a;
            is_div  <= op_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz_q    <= op_div && (src_b == '0);
            cnt     <= '0;
`ifdef MDU_MADD_EN
            macc    <= (op == OP_MADD) || (op == OP_MSUB);
            msub    <= (op == OP_MSUB);
`endif
          end
        end
        CALC: if (!flush) begin
          acc <= step;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!flush) begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          done     <= 1'b1;
          div_zero <= is_div & dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: 64-bit arithmetic reference model checked every cycle,
// plus hand-computed results for each directed vector.
module tb_mdu_iter;
  localparam int W = 32;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         flush = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {div_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] a, b, h, l);
    longint      sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    u  = '0;
    case (o)
      3'd0: begin u = sa * sb; return {1'b0, u}; end
      3'd1: begin u = {32'b0, a} * {32'b0, b}; return {1'b0, u}; end
      3'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
      3'd6: begin u = {h, l} + sa * sb; return {1'b0, u}; end
      3'd7: begin u = {h, l} - sa * sb; return {1'b0, u}; end
      default: return {1'b0, h, l};
    endcase
  endfunction

  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic [64:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0; m_dz = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_dz = m_res[64]; m_done = 1'b1;
          end
        end
      end else if (start && !flush) begin
        if (op == 3'd4) m_hi = src_a;
        else if (op == 3'd5) m_lo = src_a;
        else if (op < 3'd4 || MADD_EN) begin
          m_res  = model_op(op, src_a, src_b, m_hi, m_lo);
          m_left = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("cyc_busy", {63'b0, busy}, {63'b0, m_left != 0});
      chk("cyc_done", {63'b0, done}, {63'b0, m_done});
      chk("cyc_div_zero", {63'b0, div_zero}, {63'b0, m_dz});
      chk("cyc_hi", {32'b0, hi}, {32'b0, m_hi});
      chk("cyc_lo", {32'b0, lo}, {32'b0, m_lo});
    end
  end

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk("done_seen", {63'b0, done}, 64'd1);
  endtask

  // Caller sits on a negedge with the unit idle, so consecutive calls are back-to-back.
  task automatic op_chk(input string nm, input logic [2:0] o, input logic [31:0] a, b,
                        input logic [31:0] ehi, elo, input logic edz);
    int nb;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(W + 1));
    chk({nm, "_hi"}, {32'b0, hi}, {32'b0, ehi});
    chk({nm, "_lo"}, {32'b0, lo}, {32'b0, elo});
    chk({nm, "_div_zero"}, {63'b0, div_zero}, {63'b0, edz});
  endtask

  task automatic pulse(input logic [2:0] o, input logic [31:0] a, b, input logic fl);
    start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int nb;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    op_chk("mult_m1x2",   3'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    op_chk("multu_m1x2",  3'd1, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0);
    op_chk("multu_max",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    op_chk("mult_minmin", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    op_chk("mult_7xm3",   3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    op_chk("div_m7d2",    3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    op_chk("div_7dm2",    3'd2, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    op_chk("div_min_m1",  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    op_chk("divu_5d0",    3'd3, 32'h5,        32'h0,        32'h00000005, 32'hFFFFFFFF, 1'b1);
    op_chk("div_m8d0",    3'd2, 32'hFFFFFFF8, 32'h0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);
    op_chk("divu_maxd16", 3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0);
    op_chk("divu_3d7",    3'd3, 32'h3,        32'h7,        32'h00000003, 32'h00000000, 1'b0);

    // flush during CALC at busy cycle 10
    pulse(3'd0, 32'h3, 32'h4, 1'b0);
    repeat (9) @(negedge clk);
    chk("flush_calc_busy_before", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_calc_busy", {63'b0, busy}, 64'd0);
    chk("flush_calc_done", {63'b0, done}, 64'd0);
    chk("flush_calc_hi", {32'b0, hi}, 64'h3);
    chk("flush_calc_lo", {32'b0, lo}, 64'h0);

    // flush in the FIX cycle (busy cycle W+1) suppresses the write
    pulse(3'd1, 32'h3, 32'h5, 1'b0);
    repeat (W) @(negedge clk);
    chk("flush_fix_busy_before", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_fix_busy", {63'b0, busy}, 64'd0);
    chk("flush_fix_done", {63'b0, done}, 64'd0);
    chk("flush_fix_hi", {32'b0, hi}, 64'h3);
    chk("flush_fix_lo", {32'b0, lo}, 64'h0);

    // start while busy is ignored
    pulse(3'd1, 32'h3, 32'h5, 1'b0);
    repeat (4) @(negedge clk);
    pulse(3'd4, 32'hDEAD, 32'h0, 1'b0);
    pulse(3'd3, 32'h9, 32'h2, 1'b0);
    wait_done(nb);
    chk("busy_start_hi", {32'b0, hi}, 64'h0);
    chk("busy_start_lo", {32'b0, lo}, 64'hF);

    pulse(3'd5, 32'h1234, 32'h0, 1'b0);
    chk("mtlo_lo", {32'b0, lo}, 64'h1234);
    chk("mtlo_busy", {63'b0, busy}, 64'd0);
    pulse(3'd4, 32'hABCD, 32'h0, 1'b0);
    chk("mthi_hi", {32'b0, hi}, 64'hABCD);
    pulse(3'd4, 32'hBEEF, 32'h0, 1'b1);
    chk("mthi_flush_hi", {32'b0, hi}, 64'hABCD);
    pulse(3'd0, 32'h3, 32'h3, 1'b1);
    chk("mult_flush_busy", {63'b0, busy}, 64'd0);

`ifdef MDU_MADD_EN
    pulse(3'd4, 32'h0, 32'h0, 1'b0);
    pulse(3'd5, 32'hFFFFFFFF, 32'h0, 1'b0);
    op_chk("madd_1x1", 3'd6, 32'h1, 32'h1, 32'h00000001, 32'h00000000, 1'b0);
    op_chk("msub_1x1", 3'd7, 32'h1, 32'h1, 32'h00000000, 32'hFFFFFFFF, 1'b0);
`else
    pulse(3'd6, 32'h1, 32'h1, 1'b0);
    chk("op6_busy", {63'b0, busy}, 64'd0);
    pulse(3'd7, 32'h1, 32'h1, 1'b0);
    chk("op7_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    chk("op67_hi", {32'b0, hi}, 64'hABCD);
    chk("op67_lo", {32'b0, lo}, 64'h1234);
`endif

    // asynchronous reset mid-DIVU
    pulse(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_hi", {32'b0, hi}, 64'd0);
    chk("arst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op_chk("divu_100d7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
